// File: rtl/demux_pkg.sv
`default_nettype none
//==============================================================================
// Module   : demux_pkg
// Purpose  : Shared sizes and the per-lane storage type for the 1-to-8 byte
//            router (demux_roteador_1p8) and its lane registers (demux_lane).
// Contents : LANES, DATA_W, SEL_W, lane_t {data, valid}
// Revision : 1.0 - initial release
//==============================================================================
package demux_pkg;

   localparam int LANES  = 8;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 3;

   // One output lane: the held byte plus its "unconsumed" flag.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              valid;
   } lane_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_lane.sv
`default_nettype none
//==============================================================================
// Module   : demux_lane
// Purpose  : One output lane of the router: a data register and a valid flag.
//            A load captures din and raises valid; an ack on a valid lane
//            lowers valid while the data keeps its last value. A load always
//            wins over a same-cycle ack so back-to-back bytes see no bubble.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset (clears data and valid)
//            load   - capture din this edge
//            ack    - consumer takes the held byte this edge
//            din    - byte to capture
//            lane   - registered {data, valid}
// Revision : 1.0 - initial release
//==============================================================================
module demux_lane
   import demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              ack,
   input  logic [DATA_W-1:0] din,
   output lane_t             lane
);

   lane_t r_lane;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lane.data  <= '0;
         r_lane.valid <= 1'b0;
      end else if (load) begin
         r_lane.data  <= din;
         r_lane.valid <= 1'b1;
      end else if (ack && r_lane.valid) begin
         // Data is kept on purpose; only the ownership flag drops.
         r_lane.valid <= 1'b0;
      end
   end

   assign lane = r_lane;

endmodule : demux_lane
`default_nettype wire

// File: rtl/demux_roteador_1p8.sv
`default_nettype none
//==============================================================================
// Module   : demux_roteador_1p8
// Purpose  : Routes a valid/ready byte stream into one of eight output lanes,
//            either by an explicit lane select or round-robin. A full target
//            lane stalls the source (round-robin never skips a full lane).
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            din        - byte to route
//            din_valid  - din holds a byte this cycle
//            din_ready  - block accepts din this cycle (combinational)
//            sel        - explicit target lane (rr_mode = 0)
//            rr_mode    - 0: explicit sel, 1: round-robin on rr_ptr
//            dout       - eight lane registers, lane k at dout[8k+7:8k]
//            dout_valid - bit k: lane k holds an unconsumed byte
//            dout_ack   - bit k: consumer takes lane k this cycle
//            rr_ptr     - current round-robin target lane
// Revision : 1.0 - initial release
//==============================================================================
module demux_roteador_1p8
   import demux_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        din,
   input  logic                     din_valid,
   output logic                     din_ready,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     rr_mode,
   output logic [LANES*DATA_W-1:0]  dout,
   output logic [LANES-1:0]         dout_valid,
   input  logic [LANES-1:0]         dout_ack,
   output logic [SEL_W-1:0]         rr_ptr
);

   logic [SEL_W-1:0] r_rr_ptr;
   logic [SEL_W-1:0] w_target;
   logic             w_transfer;
   logic [LANES-1:0] w_load;
   lane_t            w_lanes [LANES];

   // Target follows sel/rr_mode in the same cycle.
   assign w_target   = rr_mode ? r_rr_ptr : sel;

   // A lane being acked this cycle is free for a new byte on the same edge.
   assign din_ready  = ~dout_valid[w_target] | dout_ack[w_target];
   assign w_transfer = din_valid & din_ready;

   // The pointer advances only on round-robin transfers, so it is preserved
   // across explicit-mode traffic and mode switches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_transfer && rr_mode) begin
         r_rr_ptr <= r_rr_ptr + 3'd1;
      end
   end

   assign rr_ptr = r_rr_ptr;

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         assign w_load[k] = w_transfer && (w_target == SEL_W'(k));

         demux_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (w_load[k]),
            .ack   (dout_ack[k]),
            .din   (din),
            .lane  (w_lanes[k])
         );

         assign dout[k*DATA_W +: DATA_W] = w_lanes[k].data;
         assign dout_valid[k]            = w_lanes[k].valid;
      end
   endgenerate

endmodule : demux_roteador_1p8
`default_nettype wire

// File: tb/tb_demux_roteador_1p8.sv
`default_nettype none
//==============================================================================
// Module   : tb_demux_roteador_1p8
// Purpose  : Self-checking bench for demux_roteador_1p8. Every accepted byte
//            is pushed to a scoreboard with its expected lane and popped and
//            compared after the capturing edge; register and handshake state
//            is compared against directed constants.
// Revision : 1.0 - initial release
//==============================================================================
module tb_demux_roteador_1p8;

   logic        clk;
   logic        rst_n;
   logic [7:0]  din;
   logic        din_valid;
   logic        din_ready;
   logic [2:0]  sel;
   logic        rr_mode;
   logic [63:0] dout;
   logic [7:0]  dout_valid;
   logic [7:0]  dout_ack;
   logic [2:0]  rr_ptr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         lane;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];

   demux_roteador_1p8 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .sel        (sel),
      .rr_mode    (rr_mode),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ack   (dout_ack),
      .rr_ptr     (rr_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one byte, confirm it is accepted, queue its expected landing
   // lane, clock it in and compare the landed lane against the scoreboard.
   task automatic send(input logic rrm, input logic [2:0] s, input logic [7:0] d,
                       input int exp_lane);
      exp_t e;
      rr_mode   = rrm;
      sel       = s;
      din       = d;
      din_valid = 1'b1;
      #1;
      check("send_ready", {63'd0, din_ready}, 64'd1);
      sb.push_back('{lane: exp_lane, data: d});
      step();
      din_valid = 1'b0;
      if (sb.size() == 0) begin
         check("sb_underflow", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check("lane_data",  {56'd0, dout[e.lane*8 +: 8]}, {56'd0, e.data});
         check("lane_valid", {63'd0, dout_valid[e.lane]}, 64'd1);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      din       = 8'h00;
      din_valid = 1'b0;
      sel       = 3'd0;
      rr_mode   = 1'b0;
      dout_ack  = 8'h00;

      // Reset state
      step();
      step();
      check("rst_dout",  dout, 64'd0);
      check("rst_valid", {56'd0, dout_valid}, 64'd0);
      check("rst_ptr",   {61'd0, rr_ptr}, 64'd0);
      rst_n = 1'b1;

      // First transfer after release: sel=5, 0xA5
      send(1'b0, 3'd5, 8'hA5, 5);
      check("sel5_valid", {56'd0, dout_valid}, 64'h20);
      check("sel5_ptr",   {61'd0, rr_ptr}, 64'd0);
      dout_ack = 8'h20;
      step();
      dout_ack = 8'h00;
      check("ack5_valid", {56'd0, dout_valid}, 64'h00);
      check("ack5_hold",  {56'd0, dout[47:40]}, 64'hA5);

      // Round-robin, 9 bytes, all lanes acked every cycle
      dout_ack = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         send(1'b1, 3'd0, 8'h10 + 8'(i), i % 8);
      end
      check("rr9_ptr",   {61'd0, rr_ptr}, 64'd1);
      check("rr9_valid", {56'd0, dout_valid}, 64'h01);
      check("rr9_dout",  dout, 64'h1716151413121118);
      step();
      dout_ack = 8'h00;
      check("rr9_drain", {56'd0, dout_valid}, 64'h00);

      // Ack on empty lanes is ignored
      dout_ack = 8'hFF;
      step();
      dout_ack = 8'h00;
      check("ackempty_valid", {56'd0, dout_valid}, 64'h00);
      check("ackempty_dout",  dout, 64'h1716151413121118);
      check("ackempty_ptr",   {61'd0, rr_ptr}, 64'd1);

      // Multi-lane ack
      send(1'b0, 3'd0, 8'hC0, 0);
      send(1'b0, 3'd7, 8'hC7, 7);
      check("multi_pre", {56'd0, dout_valid}, 64'h81);
      dout_ack = 8'h81;
      step();
      dout_ack = 8'h00;
      check("multi_post", {56'd0, dout_valid}, 64'h00);

      // Full lane stalls; ack on the same edge lets the new byte in
      send(1'b0, 3'd3, 8'h33, 3);
      sel       = 3'd3;
      din       = 8'h55;
      din_valid = 1'b1;
      #1;
      check("full_ready", {63'd0, din_ready}, 64'd0);
      step();
      check("full_hold_data",  {56'd0, dout[31:24]}, 64'h33);
      check("full_hold_valid", {56'd0, dout_valid}, 64'h08);
      dout_ack = 8'h08;
      send(1'b0, 3'd3, 8'h77, 3);
      dout_ack = 8'h00;
      check("ackload_valid", {56'd0, dout_valid}, 64'h08);
      dout_ack = 8'h08;
      step();
      dout_ack = 8'h00;

      // Round-robin pointer survives explicit-mode traffic
      dout_ack = 8'hFF;
      for (int i = 1; i <= 5; i++) begin
         send(1'b1, 3'd0, 8'h60 + 8'(i), i);
      end
      check("ptr6", {61'd0, rr_ptr}, 64'd6);
      send(1'b0, 3'd1, 8'hE1, 1);
      send(1'b0, 3'd1, 8'hE2, 1);
      check("ptr6_hold", {61'd0, rr_ptr}, 64'd6);
      send(1'b1, 3'd1, 8'hE6, 6);
      check("ptr7", {61'd0, rr_ptr}, 64'd7);
      step();
      dout_ack = 8'h00;
      check("rr_drain", {56'd0, dout_valid}, 64'h00);

      // Asynchronous reset between edges
      send(1'b0, 3'd0, 8'hA0, 0);
      send(1'b0, 3'd2, 8'hA2, 2);
      check("pre_rst_valid", {56'd0, dout_valid}, 64'h05);
      #2;
      rst_n     = 1'b0;
      rr_mode   = 1'b0;
      sel       = 3'd4;
      din       = 8'hEE;
      din_valid = 1'b1;
      #1;
      check("arst_valid", {56'd0, dout_valid}, 64'h00);
      check("arst_dout",  dout, 64'd0);
      check("arst_ptr",   {61'd0, rr_ptr}, 64'd0);
      step();
      rst_n     = 1'b1;
      din_valid = 1'b0;
      #1;
      check("rel_valid", {56'd0, dout_valid}, 64'h00);
      send(1'b0, 3'd4, 8'h44, 4);
      check("rel_first", {56'd0, dout_valid}, 64'h10);

      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard bound so the run always terminates.
   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_demux_roteador_1p8
`default_nettype wire

// File: doc/demux_roteador_1p8.md
DEMUX_ROTEADOR_1P8 -- requirements
Module: demux_roteador_1p8

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 din  input  8  data byte to route.
REQ-004 din_valid  input  1  din holds a byte to transfer this cycle.
REQ-005 din_ready  output  1  block accepts din this cycle.
REQ-006 sel  input  3  explicit target lane, used when rr_mode=0.
REQ-007 rr_mode  input  1  0 = explicit sel routing, 1 = round-robin routing.
REQ-008 dout  output  64  eight 8-bit lane registers; lane k occupies dout[8k+7:8k].
REQ-009 dout_valid  output  8  bit k set = lane k holds an unconsumed byte.
REQ-010 dout_ack  input  8  bit k = consumer takes lane k this cycle.
REQ-011 rr_ptr  output  3  current round-robin target lane.

Function
REQ-012 The target lane SHALL be rr_ptr when rr_mode=1, otherwise sel.
REQ-013 din_ready SHALL be combinational: ~dout_valid[target] | dout_ack[target].
REQ-014 A transfer SHALL occur on a clock edge where din_valid=1 and din_ready=1.
REQ-015 On a transfer, the target lane SHALL load din and set its dout_valid bit at that edge (1-cycle latency).
REQ-016 On an edge where dout_ack[k]=1 and dout_valid[k]=1 with no load to lane k, dout_valid[k] SHALL clear; dout[k] SHALL hold its last value.
REQ-017 Simultaneous ack and load on the same lane SHALL leave dout_valid[k]=1 with the new byte (no bubble, no loss).
REQ-018 dout_ack[k] on a lane with dout_valid[k]=0 SHALL be ignored.
REQ-019 Lanes not targeted and not acked SHALL hold data and valid unchanged.
REQ-020 rr_ptr SHALL increment by 1 on each transfer made in rr_mode=1 and wrap from 7 to 0.
REQ-021 rr_ptr SHALL hold when rr_mode=0 and across rr_mode changes; it SHALL NOT skip full lanes (the block stalls on a full target).
REQ-022 din_valid=1 with din_ready=0 SHALL cause no state change; the source holds din.
REQ-023 Multiple lanes MAY be acked in the same cycle, each handled independently.
REQ-024 sel and rr_mode changes SHALL take effect in the same cycle (combinational target).

Reset
REQ-025 rst_n=0 SHALL immediately force dout=0, dout_valid=0 and rr_ptr=0, independent of clk.
REQ-026 Reset asserted mid-transfer SHALL discard the byte; no lane is valid after release.
REQ-027 The first transfer after release SHALL occur on the first qualifying rising edge with rst_n=1.

Structure
REQ-028 A shared package demux_pkg SHALL hold LANES=8, DATA_W=8, SEL_W=3 and a lane_t struct (data, valid).
REQ-029 A sub-module demux_lane (one data register + valid flag, load/ack inputs, async reset) SHALL be instantiated LANES times.
REQ-030 Target select, ready logic and rr_ptr counter SHALL reside in the top module.

Verification
REQ-031 Reset release, rr_mode=0, sel=5, din=0xA5 valid one cycle -> next cycle dout_valid=8'h20, lane5=0xA5, rr_ptr=0.
REQ-032 rr_mode=1, 9 bytes 0x10..0x18 with all lanes acked each cycle -> lanes 0..7 receive 0x10..0x17, 9th byte to lane 0 (0x18), rr_ptr=1.
REQ-033 Lane 3 full, no ack, sel=3, din_valid=1 -> din_ready=0, lane3 unchanged; assert dout_ack[3] with din=0x77 -> same edge loads 0x77, dout_valid[3] stays 1.
REQ-034 dout_ack=8'hFF with dout_valid=8'h00 -> no state change; dout_ack=8'h81 with valid=8'h81 -> valid=8'h00.
REQ-035 rst_n pulsed low between clock edges with lanes 0,2 valid -> dout_valid=0, dout=0, rr_ptr=0 before the next edge.
REQ-036 rr_mode=1, rr_ptr=6, then rr_mode=0 with two transfers on sel=1 -> rr_ptr remains 6; back to rr_mode=1 -> next byte lands in lane 6.
